// File: rtl/nes_pad_scanner.sv
// nes_pad_scanner: scans NUM_CH serial NES/SNES pads in lock-step and
// publishes a frame-atomic, active-high button vector with change flags.
module nes_pad_scanner #(
    parameter int NUM_CH   = 2,
    parameter int NUM_BITS = 8,
    parameter int CLK_HZ   = 100_000_000,
    parameter int LATCH_US = 12,
    parameter int HALF_US  = 6,
    parameter int POLL_HZ  = 60
) (
    input  logic                       sysclk,
    input  logic                       reset_high,
    input  logic                       enable,
    input  logic                       scan_req,
    input  logic [NUM_CH-1:0]          nes_data,
    output logic [NUM_CH-1:0]          nes_latch,
    output logic [NUM_CH-1:0]          nes_pulse,
    output logic [NUM_CH*NUM_BITS-1:0] buttons,
    output logic                       buttons_valid,
    output logic [NUM_CH-1:0]          changed,
    output logic [15:0]                frame_cnt,
    output logic                       busy
);
    localparam int LATCH_CYC = CLK_HZ / 1_000_000 * LATCH_US;
    localparam int HALF_CYC  = CLK_HZ / 1_000_000 * HALF_US;
    localparam int POLL_CYC  = CLK_HZ / POLL_HZ;
    localparam int MAX_CYC   = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
    localparam int TW        = $clog2(MAX_CYC) + 1;
    localparam int PW        = $clog2(POLL_CYC) + 1;
    localparam int KW        = $clog2(NUM_BITS);

    localparam logic [TW-1:0] LATCH_END = TW'(LATCH_CYC - 1);
    localparam logic [TW-1:0] HALF_END  = TW'(HALF_CYC - 1);
    localparam logic [PW-1:0] POLL_END  = PW'(POLL_CYC - 1);
    localparam logic [KW-1:0] K_END     = KW'(NUM_BITS - 1);

    typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} state_t;

    state_t                     state, state_next;
    logic [NUM_CH-1:0]          sync_a, sync_b;
    logic [PW-1:0]              poll_cnt;
    logic [TW-1:0]              t;
    logic [KW-1:0]              k;
    logic                       pending;
    logic [NUM_CH*NUM_BITS-1:0] shreg;
    logic                       tick, start;
    logic                       latch_d, pulse_d, busy_d;
    logic [NUM_CH-1:0]          chg_d;

    assign tick  = enable && (poll_cnt == POLL_END);
    assign start = tick || scan_req;

    // pad data is asynchronous; idle high like a disconnected pad
    always_ff @(posedge sysclk or posedge reset_high) begin
        if (reset_high) begin
            sync_a <= '1;
            sync_b <= '1;
        end else begin
            sync_a <= nes_data;
            sync_b <= sync_a;
        end
    end

    always_ff @(posedge sysclk or posedge reset_high) begin
        if (reset_high)              poll_cnt <= '0;
        else if (!enable)            poll_cnt <= '0;
        else if (poll_cnt == POLL_END) poll_cnt <= '0;
        else                         poll_cnt <= poll_cnt + 1'b1;
    end

    always_ff @(posedge sysclk or posedge reset_high) begin
        if (reset_high) state <= IDLE;
        else            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start || pending) state_next = LATCH;
            LATCH:   if (t == LATCH_END)   state_next = LOW;
            LOW:     if (t == HALF_END)    state_next = HIGH;
            HIGH:    if (t == HALF_END)
                         state_next = (k == K_END) ? DONE : LOW;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        latch_d = 1'b0;
        pulse_d = 1'b0;
        busy_d  = 1'b0;
        unique case (state_next)
            LATCH:   begin latch_d = 1'b1; busy_d = 1'b1; end
            LOW:     busy_d = 1'b1;
            HIGH:    begin pulse_d = 1'b1; busy_d = 1'b1; end
            DONE:    busy_d = 1'b1;
            default: ;
        endcase
        chg_d = '0;
        for (int c = 0; c < NUM_CH; c++)
            chg_d[c] = shreg[c*NUM_BITS +: NUM_BITS]
                    != buttons[c*NUM_BITS +: NUM_BITS];
    end

    // IDLE always leaves on start|pending, so it consumes both
    always_ff @(posedge sysclk or posedge reset_high) begin
        if (reset_high)         pending <= 1'b0;
        else if (state == IDLE) pending <= 1'b0;
        else if (start)         pending <= 1'b1;
    end

    always_ff @(posedge sysclk or posedge reset_high) begin
        if (reset_high) begin
            t     <= '0;
            k     <= '0;
            shreg <= '0;
        end else begin
            if (state_next != state || state == IDLE) t <= '0;
            else                                      t <= t + 1'b1;
            if (state == LATCH)
                k <= '0;
            else if (state == HIGH && t == HALF_END)
                k <= k + 1'b1;
            if (state == LOW && t == HALF_END)
                for (int c = 0; c < NUM_CH; c++)
                    shreg[c*NUM_BITS + int'(k)] <= ~sync_b[c];
        end
    end

    always_ff @(posedge sysclk or posedge reset_high) begin
        if (reset_high) begin
            nes_latch     <= '0;
            nes_pulse     <= '0;
            busy          <= 1'b0;
            buttons       <= '0;
            buttons_valid <= 1'b0;
            changed       <= '0;
            frame_cnt     <= '0;
        end else begin
            nes_latch     <= {NUM_CH{latch_d}};
            nes_pulse     <= {NUM_CH{pulse_d}};
            busy          <= busy_d;
            buttons_valid <= (state == DONE);
            if (state == DONE) begin
                buttons   <= shreg;
                changed   <= chg_d;
                frame_cnt <= frame_cnt + 1'b1;
            end else begin
                changed   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_nes_pad_scanner.sv
// tb_nes_pad_scanner: scoreboard bench for nes_pad_scanner using three
// instances (base timing, fast polling, 4ch x 16-bit) and pad models.
module tb_nes_pad_scanner;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [15:0] btn;
        logic [1:0]  chg;
        logic [15:0] fc;
    } exp_a_t;

    typedef struct {
        logic [63:0] btn;
        logic [3:0]  chg;
        logic [15:0] fc;
    } exp_c_t;

    exp_a_t sb_a[$];
    exp_a_t sb_b[$];
    exp_c_t sb_c[$];

    // DUT A: 2ch x 8 bits, 800-cycle poll
    logic        a_rst, a_en, a_req;
    logic [1:0]  a_data, a_latch, a_pulse, a_chg;
    logic [15:0] a_btn, a_fc;
    logic        a_valid, a_busy;
    logic [7:0]  a_press [2];

    nes_pad_scanner #(.NUM_CH(2), .NUM_BITS(8), .CLK_HZ(4_000_000),
        .LATCH_US(12), .HALF_US(6), .POLL_HZ(5000)) a_dut (
        .sysclk(clk), .reset_high(a_rst), .enable(a_en),
        .scan_req(a_req), .nes_data(a_data), .nes_latch(a_latch),
        .nes_pulse(a_pulse), .buttons(a_btn), .buttons_valid(a_valid),
        .changed(a_chg), .frame_cnt(a_fc), .busy(a_busy));

    // DUT B: 400-cycle poll, shorter than one frame
    logic        b_rst, b_en, b_req;
    logic [1:0]  b_data, b_latch, b_pulse, b_chg;
    logic [15:0] b_btn, b_fc;
    logic        b_valid, b_busy;
    logic [7:0]  b_press [2];

    nes_pad_scanner #(.NUM_CH(2), .NUM_BITS(8), .CLK_HZ(4_000_000),
        .LATCH_US(12), .HALF_US(6), .POLL_HZ(10_000)) b_dut (
        .sysclk(clk), .reset_high(b_rst), .enable(b_en),
        .scan_req(b_req), .nes_data(b_data), .nes_latch(b_latch),
        .nes_pulse(b_pulse), .buttons(b_btn), .buttons_valid(b_valid),
        .changed(b_chg), .frame_cnt(b_fc), .busy(b_busy));

    // DUT C: 4ch x 16 bits
    logic        c_rst, c_en, c_req;
    logic [3:0]  c_data, c_latch, c_pulse, c_chg;
    logic [63:0] c_btn;
    logic [15:0] c_fc;
    logic        c_valid, c_busy;
    logic [15:0] c_press [4];

    nes_pad_scanner #(.NUM_CH(4), .NUM_BITS(16), .CLK_HZ(4_000_000),
        .LATCH_US(12), .HALF_US(6), .POLL_HZ(5000)) c_dut (
        .sysclk(clk), .reset_high(c_rst), .enable(c_en),
        .scan_req(c_req), .nes_data(c_data), .nes_latch(c_latch),
        .nes_pulse(c_pulse), .buttons(c_btn), .buttons_valid(c_valid),
        .changed(c_chg), .frame_cnt(c_fc), .busy(c_busy));

    // pad models: latch reloads, each pulse rise shifts to the next bit
    int a_idx = 0, b_idx = 0, c_idx = 0;
    logic a_pl = 1'b0, b_pl = 1'b0, c_pl = 1'b0;

    always @(posedge clk) begin
        a_pl <= a_pulse[0];
        b_pl <= b_pulse[0];
        c_pl <= c_pulse[0];
        if (a_latch[0]) a_idx <= 0;
        else if (a_pulse[0] && !a_pl) a_idx <= a_idx + 1;
        if (b_latch[0]) b_idx <= 0;
        else if (b_pulse[0] && !b_pl) b_idx <= b_idx + 1;
        if (c_latch[0]) c_idx <= 0;
        else if (c_pulse[0] && !c_pl) c_idx <= c_idx + 1;
    end

    always_comb begin
        a_data = '0;
        b_data = '0;
        c_data = '0;
        for (int c = 0; c < 2; c++) begin
            a_data[c] = (a_idx < 8) ? ~a_press[c][a_idx[2:0]] : 1'b0;
            b_data[c] = (b_idx < 8) ? ~b_press[c][b_idx[2:0]] : 1'b0;
        end
        for (int c = 0; c < 4; c++)
            c_data[c] = (c_idx < 16) ? ~c_press[c][c_idx[3:0]] : 1'b0;
    end

    task automatic run_frame_a(output int lat, output int pul,
                               output int len, output bit ok);
        logic pp;
        lat = 0; pul = 0; len = 0; ok = 1'b0; pp = 1'b0;
        for (int i = 0; i < 3000 && !a_busy; i++) @(negedge clk);
        if (!a_busy) return;
        for (int i = 0; i < 2000 && a_busy; i++) begin
            len++;
            if (a_latch[0]) lat++;
            if (a_pulse[0] && !pp) pul++;
            pp = a_pulse[0];
            @(negedge clk);
        end
        ok = !a_busy;
    endtask

    task automatic pulse_a_req();
        @(negedge clk); a_req = 1'b1;
        @(negedge clk); a_req = 1'b0;
    endtask

    task automatic test_reset();
        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
        a_en = 1'b0; b_en = 1'b0; c_en = 1'b0;
        a_req = 1'b0; b_req = 1'b0; c_req = 1'b0;
        for (int c = 0; c < 2; c++) begin a_press[c] = '0; b_press[c] = '0; end
        for (int c = 0; c < 4; c++) c_press[c] = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({a_latch, a_pulse, a_btn, a_valid, a_chg, a_fc, a_busy} !== '0) begin
            $display("FAIL reset_state got %h required 0",
                     {a_latch, a_pulse, a_btn, a_valid, a_chg, a_fc, a_busy});
            miscompares++;
        end
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    endtask

    task automatic test_first_frame();
        int lat, pul, len; bit ok; exp_a_t e;
        a_en = 1'b1;
        sb_a.push_back('{16'h0000, 2'b00, 16'd1});
        run_frame_a(lat, pul, len, ok);
        e = sb_a.pop_front();
        vectors++;
        if (!ok || {a_valid, a_btn, a_chg, a_fc} !== {1'b1, e.btn, e.chg, e.fc}) begin
            $display("FAIL first_frame ok=%0d got %h required %h", ok,
                     {a_valid, a_btn, a_chg, a_fc}, {1'b1, e.btn, e.chg, e.fc});
            miscompares++;
        end
        vectors++;
        if (lat !== 48) begin
            $display("FAIL latch_len got %0d required 48", lat); miscompares++;
        end
        vectors++;
        if (pul !== 8) begin
            $display("FAIL pulse_count got %0d required 8", pul); miscompares++;
        end
        vectors++;
        if (len !== 433) begin
            $display("FAIL frame_len got %0d required 433", len); miscompares++;
        end
    endtask

    task automatic test_buttons();
        int lat, pul, len; bit ok; exp_a_t e;
        a_press[0] = 8'h09;
        a_press[1] = 8'h80;
        sb_a.push_back('{16'h8009, 2'b11, 16'd2});
        sb_a.push_back('{16'h8009, 2'b00, 16'd3});
        for (int f = 0; f < 2; f++) begin
            run_frame_a(lat, pul, len, ok);
            e = sb_a.pop_front();
            vectors++;
            if (!ok || {a_valid, a_btn, a_chg, a_fc} !== {1'b1, e.btn, e.chg, e.fc}) begin
                $display("FAIL buttons_frame%0d ok=%0d got %h required %h", f, ok,
                         {a_valid, a_btn, a_chg, a_fc}, {1'b1, e.btn, e.chg, e.fc});
                miscompares++;
            end
        end
        a_en = 1'b0;
    endtask

    task automatic test_scan_req();
        int lat, pul, len, nv; bit ok; exp_a_t e;
        sb_a.push_back('{16'h8009, 2'b00, 16'd4});
        sb_a.push_back('{16'h8009, 2'b00, 16'd5});
        fork
            run_frame_a(lat, pul, len, ok);
            begin
                pulse_a_req();
                repeat (100) @(negedge clk);
                pulse_a_req();
                repeat (150) @(negedge clk);
                pulse_a_req();
            end
        join
        for (int f = 0; f < 2; f++) begin
            e = sb_a.pop_front();
            vectors++;
            if (!ok || len !== 433 || a_busy !== 1'b0 ||
                {a_valid, a_btn, a_chg, a_fc} !== {1'b1, e.btn, e.chg, e.fc}) begin
                $display("FAIL scan_req_frame%0d ok=%0d len=%0d got %h required %h",
                         f, ok, len, {a_valid, a_btn, a_chg, a_fc},
                         {1'b1, e.btn, e.chg, e.fc});
                miscompares++;
            end
            if (f == 0) begin
                @(negedge clk);
                vectors++;
                if (a_busy !== 1'b1) begin
                    $display("FAIL one_idle_cycle busy got %b required 1", a_busy);
                    miscompares++;
                end
                run_frame_a(lat, pul, len, ok);
            end
        end
        nv = 0;
        repeat (1200) begin
            @(negedge clk);
            if (a_valid || a_busy) nv++;
        end
        vectors++;
        if (nv !== 0) begin
            $display("FAIL no_third_frame active cycles got %0d required 0", nv);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid();
        int lat, pul, len, np; bit ok; logic pp; exp_a_t e;
        a_press[0] = 8'h41;
        a_press[1] = 8'h02;
        pulse_a_req();
        np = 0; pp = 1'b0;
        for (int i = 0; i < 1000 && !(np == 4 && !a_pulse[0]); i++) begin
            @(negedge clk);
            if (a_pulse[0] && !pp) np++;
            pp = a_pulse[0];
        end
        repeat (5) @(negedge clk);
        #2 a_rst = 1'b1;
        #1;
        vectors++;
        if (np !== 4 || {a_latch, a_pulse, a_btn, a_busy, a_valid, a_fc} !== '0) begin
            $display("FAIL reset_mid np=%0d got %h required 0", np,
                     {a_latch, a_pulse, a_btn, a_busy, a_valid, a_fc});
            miscompares++;
        end
        @(negedge clk);
        a_rst = 1'b0;
        sb_a.push_back('{16'h0241, 2'b11, 16'd1});
        fork
            run_frame_a(lat, pul, len, ok);
            pulse_a_req();
        join
        e = sb_a.pop_front();
        vectors++;
        if (!ok || pul !== 8 || len !== 433 ||
            {a_valid, a_btn, a_chg, a_fc} !== {1'b1, e.btn, e.chg, e.fc}) begin
            $display("FAIL after_reset_frame ok=%0d pul=%0d len=%0d got %h required %h",
                     ok, pul, len, {a_valid, a_btn, a_chg, a_fc},
                     {1'b1, e.btn, e.chg, e.fc});
            miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        int nf, bc, last; exp_a_t e;
        b_press[0] = 8'h12;
        b_press[1] = 8'h34;
        for (int f = 1; f <= 4; f++)
            sb_b.push_back('{16'h3412, (f == 1) ? 2'b11 : 2'b00, 16'(f)});
        b_en = 1'b1;
        nf = 0; bc = 0; last = 0;
        for (int i = 0; i < 5000 && nf < 4; i++) begin
            @(negedge clk);
            if (b_busy) bc++;
            if (b_valid) begin
                e = sb_b.pop_front();
                vectors++;
                if ({b_btn, b_chg, b_fc} !== {e.btn, e.chg, e.fc} || bc !== 433) begin
                    $display("FAIL b2b_frame%0d busy=%0d got %h required %h busy 433",
                             nf, bc, {b_btn, b_chg, b_fc}, {e.btn, e.chg, e.fc});
                    miscompares++;
                end
                if (nf > 0) begin
                    vectors++;
                    if (cyc - last !== 434) begin
                        $display("FAIL b2b_period got %0d required 434", cyc - last);
                        miscompares++;
                    end
                end
                last = cyc; bc = 0; nf++;
            end
        end
        vectors++;
        if (nf !== 4) begin
            $display("FAIL b2b_timeout frames got %0d required 4", nf);
            miscompares++;
        end
        b_en = 1'b0;
    endtask

    task automatic test_wide_wrap();
        int pul, len; logic pp; exp_c_t e;
        c_press[0] = 16'h0A55;
        c_press[1] = 16'h0FFF;
        c_press[2] = 16'h0001;
        c_press[3] = 16'h0000;
        force c_dut.frame_cnt = 16'hFFFF;
        @(negedge clk);
        release c_dut.frame_cnt;
        sb_c.push_back('{64'h0000_0001_0FFF_0A55, 4'b0111, 16'h0000});
        @(negedge clk); c_req = 1'b1;
        @(negedge clk); c_req = 1'b0;
        pul = 0; len = 0; pp = 1'b0;
        for (int i = 0; i < 20 && !c_busy; i++) @(negedge clk);
        for (int i = 0; i < 2000 && c_busy; i++) begin
            len++;
            if (c_pulse[0] && !pp) pul++;
            pp = c_pulse[0];
            @(negedge clk);
        end
        e = sb_c.pop_front();
        vectors++;
        if ({c_valid, c_btn, c_chg, c_fc} !== {1'b1, e.btn, e.chg, e.fc}) begin
            $display("FAIL wide_frame got %h required %h",
                     {c_valid, c_btn, c_chg, c_fc}, {1'b1, e.btn, e.chg, e.fc});
            miscompares++;
        end
        vectors++;
        if (pul !== 16 || len !== 817) begin
            $display("FAIL wide_timing pulses %0d len %0d required 16 817", pul, len);
            miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_buttons();
        test_scan_req();
        test_reset_mid();
        test_back_to_back();
        test_wide_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
